// File: rtl/tmds_decode_multi.sv
`default_nettype none
// ============================================================================
// Module      : tmds_decode_multi
// Description : Multi-channel TMDS/DVI token decoder with per-channel bitslip
//               word-alignment FSM, derived DE and lock status.
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_decode_multi #(
    parameter int NUM_CH       = 3,
    parameter int CTRL_RUN     = 8,
    parameter int SEARCH_LEN   = 2048,
    parameter int SLIP_WAIT    = 16,
    parameter int MAX_DATA_RUN = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [10*NUM_CH-1:0] tmds_in,
    output logic [8*NUM_CH-1:0]  data_out,
    output logic [2*NUM_CH-1:0]  ctrl_out,
    output logic                 de_out,
    output logic [NUM_CH-1:0]    bitslip,
    output logic [NUM_CH-1:0]    ch_locked,
    output logic                 locked,
    output logic                 de_mismatch
);

    localparam int c_RUN_W  = $clog2(CTRL_RUN) + 1;
    localparam int c_WCNT_W = $clog2(SEARCH_LEN) + 1;
    localparam int c_SCNT_W = $clog2(SLIP_WAIT) + 1;
    localparam int c_DCNT_W = $clog2(MAX_DATA_RUN) + 1;

    // Terminal values: a counter sitting at its LAST value plus the word on
    // this edge means the limit has been reached.
    localparam logic [c_RUN_W-1:0]  c_RUN_LAST  = c_RUN_W'(CTRL_RUN - 1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(SEARCH_LEN - 1);
    localparam logic [c_SCNT_W-1:0] c_SCNT_LAST = c_SCNT_W'(SLIP_WAIT - 1);
    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST = c_DCNT_W'(MAX_DATA_RUN - 1);

    localparam logic [1:0] c_ST_SEARCH = 2'd0;
    localparam logic [1:0] c_ST_SLIP   = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    localparam logic [9:0] c_TOK_C00 = 10'b1101010100;
    localparam logic [9:0] c_TOK_C01 = 10'b0010101011;
    localparam logic [9:0] c_TOK_C10 = 10'b0101010100;
    localparam logic [9:0] c_TOK_C11 = 10'b1010101011;

    logic [NUM_CH-1:0] w_is_ctrl;
    logic              w_all_data;
    logic              w_mixed;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [9:0]          w_word;
        logic                w_ctrl_tok;
        logic [1:0]          w_ctrl_code;
        logic [7:0]          w_d;
        logic [7:0]          w_data;
        logic [7:0]          r_data;
        logic [1:0]          r_ctrl;
        logic [1:0]          r_state;
        logic [c_RUN_W-1:0]  r_run;
        logic [c_WCNT_W-1:0] r_wcnt;
        logic [c_SCNT_W-1:0] r_scnt;
        logic [c_DCNT_W-1:0] r_dcnt;
        logic                r_bitslip;
        logic                r_locked;

        assign w_word       = tmds_in[10*k +: 10];
        assign w_d          = w_word[9] ? ~w_word[7:0] : w_word[7:0];
        assign w_is_ctrl[k] = w_ctrl_tok;

        // Classify the incoming word as one of the four control tokens or data
        always_comb begin
            w_ctrl_tok  = 1'b1;
            w_ctrl_code = 2'b00;
            case (w_word)
                c_TOK_C00: w_ctrl_code = 2'b00;
                c_TOK_C01: w_ctrl_code = 2'b01;
                c_TOK_C10: w_ctrl_code = 2'b10;
                c_TOK_C11: w_ctrl_code = 2'b11;
                default:   w_ctrl_tok  = 1'b0;
            endcase
        end

        // Undo the transition-minimising stage; bit 8 picks XOR vs XNOR chaining
        always_comb begin
            w_data    = '0;
            w_data[0] = w_d[0];
            for (int i = 1; i < 8; i++) begin
                w_data[i] = w_word[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
            end
        end

        // Decoded outputs hold their last value while the other token class is present
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data <= '0;
                r_ctrl <= '0;
            end else if (w_ctrl_tok) begin
                r_ctrl <= w_ctrl_code;
            end else begin
                r_data <= w_data;
            end
        end

        // Word-alignment FSM: hunt for a control run, slip on timeout, drop lock on long data runs.
        // Every increment is guarded by its limit check, so counters never pass their limit.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= c_ST_SEARCH;
                r_run     <= '0;
                r_wcnt    <= '0;
                r_scnt    <= '0;
                r_dcnt    <= '0;
                r_bitslip <= 1'b0;
                r_locked  <= 1'b0;
            end else begin
                r_bitslip <= 1'b0;
                case (r_state)
                    c_ST_SEARCH: begin
                        if (w_ctrl_tok && (r_run >= c_RUN_LAST)) begin
                            r_state  <= c_ST_LOCKED;
                            r_locked <= 1'b1;
                            r_run    <= '0;
                            r_wcnt   <= '0;
                            r_dcnt   <= '0;
                        end else if (r_wcnt >= c_WCNT_LAST) begin
                            r_state   <= c_ST_SLIP;
                            r_bitslip <= 1'b1;
                            r_run     <= '0;
                            r_wcnt    <= '0;
                            r_scnt    <= '0;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                            r_run  <= w_ctrl_tok ? r_run + 1'b1 : '0;
                        end
                    end
                    c_ST_SLIP: begin
                        if (r_scnt >= c_SCNT_LAST) begin
                            r_state <= c_ST_SEARCH;
                            r_scnt  <= '0;
                            r_run   <= '0;
                            r_wcnt  <= '0;
                        end else begin
                            r_scnt <= r_scnt + 1'b1;
                        end
                    end
                    c_ST_LOCKED: begin
                        if (!w_ctrl_tok && (r_dcnt >= c_DCNT_LAST)) begin
                            r_state  <= c_ST_SEARCH;
                            r_locked <= 1'b0;
                            r_dcnt   <= '0;
                            r_run    <= '0;
                            r_wcnt   <= '0;
                        end else begin
                            r_dcnt <= w_ctrl_tok ? '0 : r_dcnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= c_ST_SEARCH;
                        r_locked <= 1'b0;
                        r_run    <= '0;
                        r_wcnt   <= '0;
                        r_scnt   <= '0;
                        r_dcnt   <= '0;
                    end
                endcase
            end
        end

        assign data_out[8*k +: 8] = r_data;
        assign ctrl_out[2*k +: 2] = r_ctrl;
        assign bitslip[k]         = r_bitslip;
        assign ch_locked[k]       = r_locked;
    end

    assign locked     = &ch_locked;
    assign w_all_data = ~|w_is_ctrl;
    assign w_mixed    = (|w_is_ctrl) & ~(&w_is_ctrl);

    // DE and class-disagreement flags, both qualified by the lock held before this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            de_out      <= 1'b0;
            de_mismatch <= 1'b0;
        end else begin
            de_out      <= locked & w_all_data;
            de_mismatch <= locked & w_mixed;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmds_decode_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmds_decode_multi
// Description : Self-checking bench for tmds_decode_multi: directed vector
//               table, multi-cycle alignment sequences and randomized traffic
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_decode_multi;

    localparam int NUM_CH       = 3;
    localparam int CTRL_RUN     = 8;
    localparam int SEARCH_LEN   = 2048;
    localparam int SLIP_WAIT    = 16;
    localparam int MAX_DATA_RUN = 4096;

    localparam logic [9:0] C00 = 10'h354;
    localparam logic [9:0] C01 = 10'h0AB;
    localparam logic [9:0] C10 = 10'h154;
    localparam logic [9:0] C11 = 10'h2AB;
    localparam logic [9:0] D00 = 10'h100;
    localparam logic [9:0] DFE = 10'h2FF;

    logic                 clk;
    logic                 rst;
    logic [10*NUM_CH-1:0] tmds_in;
    logic [8*NUM_CH-1:0]  data_out;
    logic [2*NUM_CH-1:0]  ctrl_out;
    logic                 de_out;
    logic [NUM_CH-1:0]    bitslip;
    logic [NUM_CH-1:0]    ch_locked;
    logic                 locked;
    logic                 de_mismatch;

    int errors = 0;
    int checks = 0;

    tmds_decode_multi #(
        .NUM_CH      (NUM_CH),
        .CTRL_RUN    (CTRL_RUN),
        .SEARCH_LEN  (SEARCH_LEN),
        .SLIP_WAIT   (SLIP_WAIT),
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tmds_in    (tmds_in),
        .data_out   (data_out),
        .ctrl_out   (ctrl_out),
        .de_out     (de_out),
        .bitslip    (bitslip),
        .ch_locked  (ch_locked),
        .locked     (locked),
        .de_mismatch(de_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    localparam int HUNT = 0, SETTLE = 1, ALIGNED = 2;
    int         m_mode   [NUM_CH];
    int         m_seen   [NUM_CH];
    int         m_streak [NUM_CH];
    int         m_settle [NUM_CH];
    int         m_drun   [NUM_CH];
    logic [7:0] e_data   [NUM_CH];
    logic [1:0] e_ctrl   [NUM_CH];
    bit         e_slip   [NUM_CH];
    bit         e_lock   [NUM_CH];
    bit         e_de, e_mm;

    function automatic int token_class(input logic [9:0] w);
        case (w)
            C00:     return 0;
            C01:     return 1;
            C10:     return 2;
            C11:     return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] tmds_byte(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] o;
        d = w[9] ? ~w[7:0] : w[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            if (w[8]) o[i] = d[i] ^ d[i-1];
            else      o[i] = (d[i] == d[i-1]);
        end
        return o;
    endfunction

    task automatic model_step(input logic [10*NUM_CH-1:0] w, input bit r);
        int cls [NUM_CH];
        int n_ctrl;
        bit was_locked;
        if (r) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_mode[k] = HUNT; m_seen[k] = 0; m_streak[k] = 0;
                m_settle[k] = 0; m_drun[k] = 0;
                e_data[k] = '0; e_ctrl[k] = '0; e_slip[k] = 0; e_lock[k] = 0;
            end
            e_de = 0; e_mm = 0;
            return;
        end
        was_locked = 1;
        n_ctrl = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            was_locked = was_locked && e_lock[k];
            cls[k] = token_class(w[10*k +: 10]);
            if (cls[k] >= 0) n_ctrl++;
        end
        e_de = was_locked && (n_ctrl == 0);
        e_mm = was_locked && (n_ctrl != 0) && (n_ctrl != NUM_CH);
        for (int k = 0; k < NUM_CH; k++) begin
            if (cls[k] < 0) e_data[k] = tmds_byte(w[10*k +: 10]);
            else            e_ctrl[k] = 2'(cls[k]);
            e_slip[k] = 0;
            case (m_mode[k])
                HUNT: begin
                    m_seen[k]++;
                    m_streak[k] = (cls[k] >= 0) ? m_streak[k] + 1 : 0;
                    if (m_streak[k] >= CTRL_RUN) begin
                        m_mode[k] = ALIGNED; e_lock[k] = 1; m_drun[k] = 0;
                    end else if (m_seen[k] >= SEARCH_LEN) begin
                        m_mode[k] = SETTLE; e_slip[k] = 1; m_settle[k] = SLIP_WAIT;
                    end
                end
                SETTLE: begin
                    m_settle[k]--;
                    if (m_settle[k] == 0) begin
                        m_mode[k] = HUNT; m_seen[k] = 0; m_streak[k] = 0;
                    end
                end
                default: begin
                    m_drun[k] = (cls[k] >= 0) ? 0 : m_drun[k] + 1;
                    if (m_drun[k] >= MAX_DATA_RUN) begin
                        m_mode[k] = HUNT; e_lock[k] = 0; m_seen[k] = 0; m_streak[k] = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check_model(input string tag);
        logic [8*NUM_CH-1:0] ed;
        logic [2*NUM_CH-1:0] ec;
        logic [NUM_CH-1:0]   el, es;
        for (int k = 0; k < NUM_CH; k++) begin
            ed[8*k +: 8] = e_data[k];
            ec[2*k +: 2] = e_ctrl[k];
            el[k] = e_lock[k];
            es[k] = e_slip[k];
        end
        checks++;
        if ({data_out, ctrl_out, ch_locked, bitslip, locked, de_out, de_mismatch} !==
            {ed, ec, el, es, &el, e_de, e_mm}) begin
            errors++;
            $display("FAIL %s t=%0t got data=%h ctrl=%b lk=%b slip=%b L=%b de=%b mm=%b want data=%h ctrl=%b lk=%b slip=%b L=%b de=%b mm=%b",
                     tag, $time, data_out, ctrl_out, ch_locked, bitslip, locked, de_out, de_mismatch,
                     ed, ec, el, es, &el, e_de, e_mm);
        end
    endtask

    // Drive one word set, clock it in, advance the model; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic [10*NUM_CH-1:0] w, input bit r);
        tmds_in = w;
        rst     = r;
        @(posedge clk);
        #1;
        model_step(w, r);
    endtask

    task automatic expect_eq(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic logic [29:0] pk(input logic [9:0] c2, input logic [9:0] c1, input logic [9:0] c0);
        return {c2, c1, c0};
    endfunction

    function automatic logic [9:0] rand_word(input int pct_ctrl);
        if ($urandom_range(0, 99) < pct_ctrl) begin
            case ($urandom_range(0, 3))
                0:       return C00;
                1:       return C01;
                2:       return C10;
                default: return C11;
            endcase
        end
        return 10'($urandom);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [29:0] w;
        bit          r;
        logic [23:0] data;
        logic [5:0]  ctrl;
        logic [2:0]  lock;
        bit          de;
        bit          mm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [29:0] w, input bit r, input logic [23:0] data,
                       input logic [5:0] ctrl, input logic [2:0] lock, input bit de, input bit mm);
        vec_t v;
        v.w = w; v.r = r; v.data = data; v.ctrl = ctrl; v.lock = lock; v.de = de; v.mm = mm;
        tbl.push_back(v);
    endtask

    initial begin
        int first_slip, second_slip, n_slip, bad_side;
        int lost_early, drop_at;
        bit slip_seen;

        rst     = 1'b1;
        tmds_in = '0;

        // reset, lock on 8 control tokens, data decode, mismatch, hold behaviour
        add(30'h0, 1, 24'h000000, 6'b000000, 3'b000, 0, 0);
        for (int i = 1; i <= 7; i++) add(pk(C00, C00, C00), 0, 24'h000000, 6'b000000, 3'b000, 0, 0);
        add(pk(C00, C00, C00), 0, 24'h000000, 6'b000000, 3'b111, 0, 0);
        add(pk(D00, D00, D00), 0, 24'h000000, 6'b000000, 3'b111, 1, 0);
        add(pk(DFE, DFE, DFE), 0, 24'hFEFEFE, 6'b000000, 3'b111, 1, 0);
        add(pk(C11, D00, C11), 0, 24'hFE00FE, 6'b110011, 3'b111, 0, 1);
        add(pk(C01, C01, C01), 0, 24'hFE00FE, 6'b010101, 3'b111, 0, 0);
        add(pk(C00, C11, C10), 0, 24'hFE00FE, 6'b001110, 3'b111, 0, 0);
        add(pk(D00, D00, D00), 0, 24'h000000, 6'b001110, 3'b111, 1, 0);
        // reset while streaming data, then relock needs 8 fresh tokens
        add(pk(D00, D00, D00), 1, 24'h000000, 6'b000000, 3'b000, 0, 0);
        for (int i = 1; i <= 7; i++) add(pk(C00, C00, C00), 0, 24'h000000, 6'b000000, 3'b000, 0, 0);
        add(pk(C00, C00, C00), 0, 24'h000000, 6'b000000, 3'b111, 0, 0);
        // a data word breaks ch1's run; mismatch stays low while not all locked
        add(30'h0, 1, 24'h000000, 6'b000000, 3'b000, 0, 0);
        for (int i = 1; i <= 4; i++) add(pk(C00, C00, C00), 0, 24'h000000, 6'b000000, 3'b000, 0, 0);
        add(pk(C00, D00, C00), 0, 24'h000000, 6'b000000, 3'b000, 0, 0);
        add(pk(C00, C00, C00), 0, 24'h000000, 6'b000000, 3'b000, 0, 0);
        add(pk(C00, C00, C00), 0, 24'h000000, 6'b000000, 3'b000, 0, 0);
        add(pk(C00, C00, C00), 0, 24'h000000, 6'b000000, 3'b101, 0, 0);
        add(pk(C00, C00, C00), 0, 24'h000000, 6'b000000, 3'b101, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].w, tbl[i].r);
            checks++;
            if ({data_out, ctrl_out, ch_locked, locked, de_out, de_mismatch, bitslip} !==
                {tbl[i].data, tbl[i].ctrl, tbl[i].lock, &tbl[i].lock, tbl[i].de, tbl[i].mm, 3'b000}) begin
                errors++;
                $display("FAIL vec%0d got data=%h ctrl=%b lk=%b L=%b de=%b mm=%b slip=%b want data=%h ctrl=%b lk=%b de=%b mm=%b slip=000",
                         i, data_out, ctrl_out, ch_locked, locked, de_out, de_mismatch, bitslip,
                         tbl[i].data, tbl[i].ctrl, tbl[i].lock, tbl[i].de, tbl[i].mm);
            end
        end

        // ch2 carries only data: slips after SEARCH_LEN words and again SEARCH_LEN+SLIP_WAIT later
        step(30'h0, 1);
        first_slip = -1; second_slip = -1; n_slip = 0; bad_side = 0;
        for (int n = 1; n <= 2*SEARCH_LEN + SLIP_WAIT + 20; n++) begin
            step(pk(D00, C00, C00), 0);
            if (bitslip[2]) begin
                n_slip++;
                if (first_slip < 0) first_slip = n;
                else if (second_slip < 0) second_slip = n;
            end
            if (bitslip[1:0] != 2'b00) bad_side++;
            if (n >= CTRL_RUN && ch_locked[1:0] != 2'b11) bad_side++;
        end
        expect_eq("slip_first_cycle", first_slip, SEARCH_LEN);
        expect_eq("slip_second_cycle", second_slip, 2*SEARCH_LEN + SLIP_WAIT);
        expect_eq("slip_pulse_count", n_slip, 2);
        expect_eq("slip_other_channels", bad_side, 0);

        // long data run drops lock exactly at MAX_DATA_RUN, with no slip
        step(30'h0, 1);
        for (int n = 1; n <= CTRL_RUN; n++) step(pk(C00, C00, C00), 0);
        expect_eq("drop_prelocked", int'(locked), 1);
        lost_early = 0; drop_at = -1; slip_seen = 0;
        for (int n = 1; n <= MAX_DATA_RUN; n++) begin
            step(pk(D00, D00, D00), 0);
            if (bitslip != 3'b000) slip_seen = 1;
            if (n < MAX_DATA_RUN && ch_locked != 3'b111) lost_early++;
            if (ch_locked == 3'b000 && drop_at < 0) drop_at = n;
        end
        expect_eq("drop_not_early", lost_early, 0);
        expect_eq("drop_cycle", drop_at, MAX_DATA_RUN);
        expect_eq("drop_de_last_locked", int'(de_out), 1);
        expect_eq("drop_no_slip", int'(slip_seen), 0);
        step(pk(D00, D00, D00), 0);
        expect_eq("drop_de_after", int'(de_out), 0);
        expect_eq("drop_locked_after", int'(locked), 0);

        // randomized traffic against the reference model
        step(30'h0, 1);
        check_model("rand_reset");
        for (int ph = 0; ph < 10; ph++) begin
            int len, pct;
            len = $urandom_range(200, 900);
            case (ph % 4)
                0:       pct = 95;
                1:       pct = 60;
                2:       pct = 20;
                default: pct = 3;
            endcase
            for (int n = 0; n < len; n++) begin
                logic [29:0] w;
                bit          r;
                int          mode;
                mode = $urandom_range(0, 9);
                if (mode < 2) begin
                    w = pk(rand_word(100), rand_word(100), rand_word(100));
                end else if (mode < 4) begin
                    w = pk(rand_word(0), rand_word(0), rand_word(0));
                end else begin
                    w = pk(rand_word(pct), rand_word(pct), rand_word(pct));
                end
                r = ($urandom_range(0, 699) == 0);
                step(w, r);
                check_model("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
